led_blink_sequencer: RTL and testbench

//  Drives the board LEDs from CLOCK_50 using a programmable tick prescaler and a pattern state machine (off/solid/blink/chase).
//  It is the stage feeding the LED pins. It generalises the fixed 1 Hz two-LED toggle into a mode-selectable, pausable sequencer.
//  It exports its tick so downstream logic can run at the pattern rate.

---
 rtl/led_seq_pkg.sv | 28 ++
 rtl/tick_gen.sv | 64 ++++++
 rtl/led_blink_sequencer.sv | 163 ++++++++++++++++
 tb/tb_led_blink_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_seq_pkg
//    Shared constants and types for the LED blink sequencer.
//    The MODE input encodings double as the state encoding of the pattern
//    state machine, so a mode request can be compared directly against the
//    current state to decide between "enter new pattern" and "advance".
//    Also holds the PWM period used by the optional brightness gate.
// ----------------------------------------------------------------------------
package led_seq_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_SOLID = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_CHASE = 2'd3;

   // State values deliberately equal the MODE encodings above.
   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_SOLID = 2'd1,
      S_BLINK = 2'd2,
      S_CHASE = 2'd3
   } state_t;

   // Brightness PWM: counter runs 0..PWM_PERIOD-1, BRIGHT selects duty 0..15.
   localparam int PWM_PERIOD = 15;
   localparam int PWM_CNT_W  = 4;

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//    Programmable prescaler producing the pattern step rate.
//    DIV = CLK_HZ / TICK_HZ; one step every DIV enabled clock cycles.
//
// Parameters
//    CLK_HZ   input clock frequency
//    TICK_HZ  step rate; DIV must be >= 1
//
// Ports
//    CLOCK_50  in   system clock (posedge)
//    RESET_N   in   asynchronous active-low reset
//    EN        in   1 = count, 0 = freeze counter (not cleared)
//    step      out  combinational step strobe, high on the cycle the counter
//                   sits at DIV-1 while enabled; the parent updates on it
//    TICK      out  registered copy of step, aligned with the LED update edge
// ----------------------------------------------------------------------------
module tick_gen #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic EN,
   output logic step,
   output logic TICK
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int CNT_W = $clog2(DIV) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   generate
      if (DIV < 1) begin : g_bad_div
         $error("tick_gen: CLK_HZ/TICK_HZ must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;
   logic             w_step;

   // With DIV=1 LAST is zero, so the step fires on every enabled cycle.
   assign w_step = EN && (r_cnt == LAST);
   assign step   = w_step;
   assign TICK   = r_tick;

   // Counter holds its value while paused so the interval resumes where it
   // left off rather than restarting.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_step;
         if (w_step) begin
            r_cnt <= '0;
         end else if (EN) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_blink_sequencer.sv
// ----------------------------------------------------------------------------
// led_blink_sequencer
//    Drives the board LEDs with a mode-selectable, pausable pattern
//    (off / solid / blink / chase) stepped by a programmable prescaler.
//    The step tick is exported so downstream logic can run at pattern rate.
//
// Optional feature macro: LED_PWM_EN
//    Defined   -> BRIGHT port exists and LEDs are gated by a free-running
//                 15-cycle PWM (BRIGHT=0 dark, BRIGHT=15 always on).
//    Undefined -> no BRIGHT port, LED is the pattern register directly.
//
// Parameters
//    CLK_HZ   input clock frequency
//    TICK_HZ  pattern step rate (CLK_HZ/TICK_HZ >= 1)
//    N_LEDS   LED count, 2..16
//
// Ports
//    CLOCK_50  in   system clock (posedge)
//    RESET_N   in   asynchronous active-low reset
//    EN        in   1 = run prescaler, 0 = pause and hold everything
//    MODE      in   0=OFF 1=SOLID 2=BLINK 3=CHASE, sampled on step edges only
//    BRIGHT    in   brightness 0..15 (LED_PWM_EN builds only)
//    LED       out  LED drive, registered
//    TICK      out  one-cycle pulse per pattern step, registered
// ----------------------------------------------------------------------------
module led_blink_sequencer
   import led_seq_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1,
   parameter int N_LEDS  = 2
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              EN,
   input  logic [1:0]        MODE,
`ifdef LED_PWM_EN
   input  logic [3:0]        BRIGHT,
`endif
   output logic [N_LEDS-1:0] LED,
   output logic              TICK
);

   localparam int POS_W = $clog2(N_LEDS);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);

   generate
      if (N_LEDS < 2 || N_LEDS > 16) begin : g_bad_n_leds
         $error("led_blink_sequencer: N_LEDS must be in 2..16");
      end
   endgenerate

   logic              w_step;
   state_t            w_mode;
   logic [POS_W-1:0]  w_next_pos;

   state_t            r_state;
   logic              r_phase;
   logic [POS_W-1:0]  r_pos;
   logic [N_LEDS-1:0] r_pattern;

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .EN       (EN),
      .step     (w_step),
      .TICK     (TICK)
   );

   // Even LEDs follow phase, odd LEDs the inverse, giving an alternating blink.
   function automatic logic [N_LEDS-1:0] blink_pattern(input logic phase);
      logic [N_LEDS-1:0] res;
      for (int i = 0; i < N_LEDS; i++) begin
         res[i] = (i % 2 == 0) ? phase : ~phase;
      end
      return res;
   endfunction

   // Compare-based decode avoids indexing past N_LEDS for non-power-of-2 counts.
   function automatic logic [N_LEDS-1:0] one_hot(input logic [POS_W-1:0] pos);
      logic [N_LEDS-1:0] res;
      for (int i = 0; i < N_LEDS; i++) begin
         res[i] = (pos == POS_W'(i));
      end
      return res;
   endfunction

   assign w_mode     = state_t'(MODE);
   assign w_next_pos = (r_pos == LAST_POS) ? '0 : r_pos + POS_W'(1);

   // Pattern state machine. Nothing moves except on a step, so MODE changes
   // between steps and EN pauses are naturally ignored. A mode request that
   // differs from the current state enters that pattern from its start;
   // a repeated request advances the current pattern one step.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= S_OFF;
         r_phase   <= 1'b0;
         r_pos     <= '0;
         r_pattern <= '0;
      end else if (w_step) begin
         if (w_mode != r_state) begin
            r_state <= w_mode;
            case (w_mode)
               S_OFF:   r_pattern <= '0;
               S_SOLID: r_pattern <= '1;
               S_BLINK: begin
                  r_phase   <= 1'b1;
                  r_pattern <= blink_pattern(1'b1);
               end
               S_CHASE: begin
                  r_pos     <= '0;
                  r_pattern <= one_hot('0);
               end
               default: r_pattern <= '0;
            endcase
         end else begin
            case (r_state)
               S_OFF:   r_pattern <= '0;
               S_SOLID: r_pattern <= '1;
               S_BLINK: begin
                  r_phase   <= ~r_phase;
                  r_pattern <= blink_pattern(~r_phase);
               end
               S_CHASE: begin
                  r_pos     <= w_next_pos;
                  r_pattern <= one_hot(w_next_pos);
               end
               default: r_pattern <= '0;
            endcase
         end
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_CNT_W-1:0] r_pwm_cnt;
   logic                 r_pwm_gate;

   // Free-running brightness PWM, independent of EN so paused LEDs keep
   // their brightness. The gate is registered so LED stays glitch-free.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pwm_cnt  <= '0;
         r_pwm_gate <= 1'b0;
      end else begin
         r_pwm_gate <= (r_pwm_cnt < BRIGHT);
         if (r_pwm_cnt == PWM_CNT_W'(PWM_PERIOD - 1)) begin
            r_pwm_cnt <= '0;
         end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_CNT_W'(1);
         end
      end
   end

   assign LED = r_pattern & {N_LEDS{r_pwm_gate}};
`else
   assign LED = r_pattern;
`endif

endmodule

// File: tb/tb_led_blink_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_blink_sequencer
//    Self-checking bench for led_blink_sequencer. Three instances share one
//    stimulus stream: N_LEDS=2 and N_LEDS=4 at DIV=10, plus N_LEDS=3 at DIV=1.
//    A behavioural model derives every output from counts of enabled cycles
//    and steps-since-mode-entry; directed literals pin the model.
//    Define LED_PWM_EN to also exercise the brightness gate.
// ----------------------------------------------------------------------------
module tb_led_blink_sequencer;
   import led_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en;
   logic [1:0] mode;
`ifdef LED_PWM_EN
   logic [3:0] bright;
`endif
   logic [1:0] led2;
   logic [3:0] led4;
   logic [2:0] led3;
   logic       tick2, tick4, tick3;

   int compared   = 0;
   int mismatched = 0;
   bit checkEn    = 0;

   always #5 clk = ~clk;

   led_blink_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .N_LEDS(2)) dut2 (
      .CLOCK_50 (clk), .RESET_N (rst_n), .EN (en), .MODE (mode),
`ifdef LED_PWM_EN
      .BRIGHT   (bright),
`endif
      .LED      (led2), .TICK (tick2));

   led_blink_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .N_LEDS(4)) dut4 (
      .CLOCK_50 (clk), .RESET_N (rst_n), .EN (en), .MODE (mode),
`ifdef LED_PWM_EN
      .BRIGHT   (bright),
`endif
      .LED      (led4), .TICK (tick4));

   led_blink_sequencer #(.CLK_HZ(10), .TICK_HZ(10), .N_LEDS(3)) dut3 (
      .CLOCK_50 (clk), .RESET_N (rst_n), .EN (en), .MODE (mode),
`ifdef LED_PWM_EN
      .BRIGHT   (bright),
`endif
      .LED      (led3), .TICK (tick3));

   // Model: index 0 -> dut2, 1 -> dut4, 2 -> dut3.
   int          cN[3]   = '{2, 4, 3};
   int          cDiv[3] = '{10, 10, 1};
   int          mEn[3]  = '{0, 0, 0};
   int          mMode[3] = '{0, 0, 0};
   int          mK[3]   = '{0, 0, 0};
   logic        mTick[3] = '{1'b0, 1'b0, 1'b0};
   logic [15:0] mPat[3] = '{16'h0, 16'h0, 16'h0};
`ifdef LED_PWM_EN
   int          mCycles = 0;
   logic        mGate   = 1'b0;
`endif

   // LED image for a mode after k advances since entering it.
   function automatic logic [15:0] patternFor(int md, int k, int n);
      logic [15:0] res;
      res = '0;
      case (md)
         1: for (int i = 0; i < n; i++) res[i] = 1'b1;
         2: for (int i = 0; i < n; i++) res[i] = ((k % 2 == 0) == (i % 2 == 0));
         3: res[k % n] = 1'b1;
         default: res = '0;
      endcase
      return res;
   endfunction

   function automatic logic [15:0] expLed(int idx);
`ifdef LED_PWM_EN
      return mGate ? mPat[idx] : 16'h0;
`else
      return mPat[idx];
`endif
   endfunction

   // Steps happen on every DIV-th enabled edge since reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            mEn[i] = 0; mMode[i] = 0; mK[i] = 0; mTick[i] = 1'b0; mPat[i] = '0;
         end
`ifdef LED_PWM_EN
         mCycles = 0; mGate = 1'b0;
`endif
      end else begin
`ifdef LED_PWM_EN
         mGate = ((mCycles % PWM_PERIOD) < int'(bright));
         mCycles++;
`endif
         for (int i = 0; i < 3; i++) begin
            mTick[i] = 1'b0;
            if (en) begin
               mEn[i]++;
               if (mEn[i] % cDiv[i] == 0) begin
                  mTick[i] = 1'b1;
                  if (int'(mode) != mMode[i]) begin
                     mMode[i] = int'(mode);
                     mK[i] = 0;
                  end else begin
                     mK[i]++;
                  end
                  mPat[i] = patternFor(mMode[i], mK[i], cN[i]);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Continuous compare against the model on every falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cmp_tick_n2", {15'b0, tick2}, {15'b0, mTick[0]});
         checkOutput("cmp_tick_n4", {15'b0, tick4}, {15'b0, mTick[1]});
         checkOutput("cmp_tick_n3", {15'b0, tick3}, {15'b0, mTick[2]});
         checkOutput("cmp_led_n2", {14'b0, led2}, expLed(0));
         checkOutput("cmp_led_n4", {12'b0, led4}, expLed(1));
         checkOutput("cmp_led_n3", {13'b0, led3}, expLed(2));
      end
   end

   // Waits for the next TICK of the DIV=10 instances; n = cycles waited.
   task automatic waitTick(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick2 && n < limit);
      if (!tick2) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL tick_timeout: got no TICK expected TICK within %0d cycles", limit);
      end
   endtask

   task automatic applyStimulus();
      int n;
      int cnt;
      logic [3:0] chaseSeq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rst_n = 1'b0; en = 1'b0; mode = MODE_BLINK;
`ifdef LED_PWM_EN
      bright = 4'd15;
`endif
      repeat (2) @(negedge clk);
      checkEn = 1;
      checkOutput("reset_led4", {12'b0, led4}, 16'h0);
      checkOutput("reset_tick2", {15'b0, tick2}, 16'h0);

      // Blink from reset: first step 10 cycles after release.
      en = 1'b1; rst_n = 1'b1;
      waitTick(20, n);
      checkOutput("t1_first_tick_cycles", 16'(n), 16'd10);
      checkOutput("t1_led2_entry", {14'b0, led2}, 16'b01);
      checkOutput("t1_led4_entry", {12'b0, led4}, 16'b0101);
      waitTick(20, n);
      checkOutput("t1_period2", 16'(n), 16'd10);
      checkOutput("t1_led2_toggle", {14'b0, led2}, 16'b10);
      waitTick(20, n);
      checkOutput("t1_period3", 16'(n), 16'd10);
      checkOutput("t1_led2_back", {14'b0, led2}, 16'b01);

      // Chase on four LEDs, including wrap.
      mode = MODE_CHASE;
      waitTick(20, n);
      checkOutput("t2_led4_entry", {12'b0, led4}, 16'b0001);
      for (int i = 0; i < 4; i++) begin
         waitTick(20, n);
         checkOutput("t2_led4_chase", {12'b0, led4}, {12'b0, chaseSeq[i]});
      end

      // Pause with the prescaler at 4.
      repeat (4) @(negedge clk);
      en = 1'b0;
      cnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (tick2 || tick4 || tick3) cnt++;
      end
      checkOutput("t3_no_tick_paused", 16'(cnt), 16'd0);
      checkOutput("t3_led4_held", {12'b0, led4}, 16'b0001);
      en = 1'b1;
      waitTick(20, n);
      checkOutput("t3_resume_cycles", 16'(n), 16'd6);
      checkOutput("t3_led4_resume", {12'b0, led4}, 16'b0010);

      // Mid-interval MODE change waits for the next step.
      mode = MODE_BLINK;
      waitTick(20, n);
      checkOutput("t4_led4_blink", {12'b0, led4}, 16'b0101);
      repeat (3) @(negedge clk);
      mode = MODE_SOLID;
      waitTick(20, n);
      checkOutput("t4_solid_cycles", 16'(n), 16'd7);
      checkOutput("t4_led4_solid", {12'b0, led4}, 16'b1111);
      checkOutput("t4_led2_solid", {14'b0, led2}, 16'b11);

      // Asynchronous reset while TICK is high mid-chase.
      mode = MODE_CHASE;
      waitTick(20, n);
      waitTick(20, n);
      checkOutput("t5_led4_pre", {12'b0, led4}, 16'b0010);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_async_led4", {12'b0, led4}, 16'h0);
      checkOutput("t5_async_led2", {14'b0, led2}, 16'h0);
      checkOutput("t5_async_tick", {15'b0, tick2}, 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      waitTick(20, n);
      checkOutput("t5_release_cycles", 16'(n), 16'd10);
      checkOutput("t5_led4_reentry", {12'b0, led4}, 16'b0001);

`ifdef LED_PWM_EN
      // Brightness duty over two full PWM periods.
      mode = MODE_SOLID;
      waitTick(20, n);
      begin
         logic [3:0] levels [3] = '{4'd5, 4'd0, 4'd15};
         for (int j = 0; j < 3; j++) begin
            bright = levels[j];
            repeat (2) @(negedge clk);
            cnt = 0;
            repeat (30) begin
               @(negedge clk);
               if (led4[0]) cnt++;
            end
            checkOutput("t6_pwm_on_cycles", 16'(cnt), 16'(2 * int'(levels[j])));
         end
      end
`endif
   endtask

   initial begin
      applyStimulus();
      checkEn = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
